// File: rtl/hdlc_rx_checker_pkg.sv
// Shared constants and types for the HDLC receive-path checker.
package hdlc_chk_pkg;

  // Line patterns observed on the serial Rx input
  localparam logic [7:0] FLAG_PATTERN  = 8'h7E;
  localparam logic [7:0] ABORT_PATTERN = 8'h7F;

  // ErrVec bit positions
  localparam int ERR_FLAG  = 0;
  localparam int ERR_ABORT = 1;
  localparam int ERR_EOF   = 2;
  localparam int ERR_OVF   = 3;
  localparam int ERR_W     = 4;

  // Frame tracking state
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_OVF   = 2'd2
  } frame_state_e;

endpackage

// File: rtl/hdlc_rx_checker_if.sv
// Rx status / error report bundle between the Rx module side and the checker.
interface hdlc_rx_checker_if
  import hdlc_chk_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic              Rx;
  logic              Rx_FlagDetect;
  logic              Rx_AbortDetect;
  logic              Rx_AbortSignal;
  logic              Rx_ValidFrame;
  logic              Rx_EoF;
  logic              Rx_NewByte;
  logic              Rx_Overflow;
  logic              ErrClr;
  logic [ERR_W-1:0]  ErrVec;
  logic [ERR_W-1:0]  ErrSticky;
  logic [CNT_W-1:0]  ErrCnt;
  logic [CNT_W-1:0]  FrameCnt;

  // Side that drives the line, the Rx strobes and the clear
  modport master (
    output Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame,
           Rx_EoF, Rx_NewByte, Rx_Overflow, ErrClr,
    input  ErrVec, ErrSticky, ErrCnt, FrameCnt
  );

  // The checker itself
  modport slave (
    input  Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame,
           Rx_EoF, Rx_NewByte, Rx_Overflow, ErrClr,
    output ErrVec, ErrSticky, ErrCnt, FrameCnt
  );
endinterface

// File: rtl/hdlc_rx_checker_sat_cnt.sv
// Saturating up-counter with variable increment and synchronous clear.
module hdlc_sat_cnt #(
  parameter int CNT_W = 16,
  parameter int INC_W = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic [INC_W-1:0] Inc,
  output logic [CNT_W-1:0] Cnt
);

  // One extra bit catches the wrap so the count can pin at all-ones
  logic [CNT_W:0] sum;
  assign sum = {1'b0, Cnt} + (CNT_W+1)'(Inc);

  // Clear wins over any increment in the same cycle
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)             Cnt <= '0;
    else if (Clr)         Cnt <= '0;
    else if (sum[CNT_W])  Cnt <= '1;
    else                  Cnt <= sum[CNT_W-1:0];
  end

endmodule

// File: rtl/hdlc_rx_checker.sv
// Run-time checker beside the HDLC Rx module: predicts flag, abort, EoF and
// overflow strobes from the line and frame activity and reports mismatches.
module hdlc_rx_checker
  import hdlc_chk_pkg::*;
#(
  parameter int FLAG_LATENCY = 2,
  parameter int OVF_BYTES    = 130,
  parameter int CNT_W        = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  hdlc_rx_checker_if.slave   bus
);

  localparam int BCNT_W = $clog2(OVF_BYTES+1);

  logic [7:0]        sr;
  logic [3:0]        fill;
  logic              flagHit;
  logic              expFlag;
  logic              vfPrev;
  logic              primed;
  logic              abortPend;
  logic              vfRise;
  logic              vfFall;
  frame_state_e      state;
  logic [BCNT_W-1:0] bcnt;
  logic              ovfPend;
  logic [ERR_W-1:0]  errNext;
  logic [ERR_W-1:0]  errVecR;
  logic [ERR_W-1:0]  sticky;
  logic [2:0]        errInc;

  // Line history; matching is suppressed until eight bits have been seen
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sr   <= '0;
      fill <= '0;
    end else begin
      sr <= {sr[6:0], bus.Rx};
      if (fill != 4'd8) fill <= fill + 4'd1;
    end
  end

  assign flagHit = (fill == 4'd8) && (sr == FLAG_PATTERN);

  // The match is already one cycle behind the last flag bit, so the
  // remaining delay to the expected strobe is FLAG_LATENCY-1 cycles
  generate
    if (FLAG_LATENCY > 1) begin : gFlagDly
      logic [FLAG_LATENCY-2:0] dly;
      // Shift the flag match towards the cycle the strobe is due
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) dly <= '0;
        else begin
          dly[0] <= flagHit;
          for (int i = 1; i < FLAG_LATENCY-1; i++) dly[i] <= dly[i-1];
        end
      end
      assign expFlag = dly[FLAG_LATENCY-2];
    end else begin : gFlagNoDly
      assign expFlag = flagHit;
    end
  endgenerate

  // Edge history of ValidFrame and the pending abort expectation. primed
  // blocks a ValidFrame already high at reset release from looking like a rise.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vfPrev    <= 1'b0;
      primed    <= 1'b0;
      abortPend <= 1'b0;
    end else begin
      vfPrev    <= bus.Rx_ValidFrame;
      primed    <= 1'b1;
      abortPend <= bus.Rx_AbortDetect && bus.Rx_ValidFrame;
    end
  end

  assign vfRise = primed && !vfPrev && bus.Rx_ValidFrame;
  // Only frames this checker saw open are closed (and EoF-checked)
  assign vfFall = vfPrev && !bus.Rx_ValidFrame && (state != S_IDLE);

  // Frame tracking: count bytes until the overflow threshold, then wait for the fall
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= S_IDLE;
      bcnt    <= '0;
      ovfPend <= 1'b0;
    end else begin
      ovfPend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vfRise) begin
            state <= S_FRAME;
            bcnt  <= '0;
          end
        end
        S_FRAME: begin
          if (vfFall) state <= S_IDLE;
          else if (bus.Rx_NewByte) begin
            bcnt <= bcnt + BCNT_W'(1);
            if (bcnt == BCNT_W'(OVF_BYTES-1)) begin
              state   <= S_OVF;
              ovfPend <= 1'b1;
            end
          end
        end
        S_OVF: begin
          if (vfFall) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Violations detected this cycle; in S_FRAME bcnt is always below the threshold
  always_comb begin
    errNext            = '0;
    errNext[ERR_FLAG]  = expFlag != bus.Rx_FlagDetect;
    errNext[ERR_ABORT] = abortPend && !bus.Rx_AbortSignal;
    errNext[ERR_EOF]   = vfFall && !bus.Rx_EoF;
    errNext[ERR_OVF]   = ((state == S_FRAME) && bus.Rx_Overflow) ||
                         (ovfPend && !bus.Rx_Overflow);
  end

  // Registered pulses always fire; only the accumulators honour the clear
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      errVecR <= '0;
      sticky  <= '0;
    end else begin
      errVecR <= errNext;
      sticky  <= bus.ErrClr ? '0 : (sticky | errNext);
    end
  end

  assign errInc        = 3'($countones(errNext));
  assign bus.ErrVec    = errVecR;
  assign bus.ErrSticky = sticky;

  hdlc_sat_cnt #(.CNT_W(CNT_W), .INC_W(3)) uErrCnt (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (bus.ErrClr),
    .Inc (errInc),
    .Cnt (bus.ErrCnt)
  );

  hdlc_sat_cnt #(.CNT_W(CNT_W), .INC_W(1)) uFrameCnt (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (bus.ErrClr),
    .Inc (vfFall),
    .Cnt (bus.FrameCnt)
  );

endmodule

// File: tb/tb_hdlc_rx_checker.sv
// Directed + randomized bench for hdlc_rx_checker; a cycle-history model
// predicts every output of a 16-bit and a 4-bit counter instance.
module tb_hdlc_rx_checker;

  localparam int FL  = 2;
  localparam int OVF = 130;

  logic clk = 1'b0;
  logic rstN;
  logic rx, fd, ad, asig, vf, eof, nb, ovf, clr;

  hdlc_rx_checker_if #(.CNT_W(16)) bus16 ();
  hdlc_rx_checker_if #(.CNT_W(4))  bus4 ();

  assign bus16.Rx = rx;             assign bus4.Rx = rx;
  assign bus16.Rx_FlagDetect = fd;  assign bus4.Rx_FlagDetect = fd;
  assign bus16.Rx_AbortDetect = ad; assign bus4.Rx_AbortDetect = ad;
  assign bus16.Rx_AbortSignal = asig; assign bus4.Rx_AbortSignal = asig;
  assign bus16.Rx_ValidFrame = vf;  assign bus4.Rx_ValidFrame = vf;
  assign bus16.Rx_EoF = eof;        assign bus4.Rx_EoF = eof;
  assign bus16.Rx_NewByte = nb;     assign bus4.Rx_NewByte = nb;
  assign bus16.Rx_Overflow = ovf;   assign bus4.Rx_Overflow = ovf;
  assign bus16.ErrClr = clr;        assign bus4.ErrClr = clr;

  hdlc_rx_checker #(.FLAG_LATENCY(FL), .OVF_BYTES(OVF), .CNT_W(16)) dut (
    .Clk(clk), .Rst(rstN), .bus(bus16));
  hdlc_rx_checker #(.FLAG_LATENCY(FL), .OVF_BYTES(OVF), .CNT_W(4)) dut4 (
    .Clk(clk), .Rst(rstN), .bus(bus4));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n = 0, base = 0, fdMode = 0, prev = 0;
  bit hRx[0:8191], hVf[0:8191], hAd[0:8191];
  bit mOpen, mReached, mOvfJust, lastAb;
  int mBytes, mCnt16, mCnt4, mFrm16, mFrm4;
  logic [3:0] mSticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, want);
      $error("%s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Flag due in cycle c: the eight line bits ending FL cycles earlier spell 0x7E
  function automatic bit expFlagAt(input int c);
    logic [7:0] b;
    if (c - FL - 7 < base) return 1'b0;
    b = '0;
    for (int k = 0; k < 8; k++) b = {b[6:0], hRx[c-FL-7+k]};
    return b == 8'h7E;
  endfunction

  // Apply the current inputs for one cycle, advance the model, check after the edge
  task automatic cyc();
    bit e, pv, pa, fall, rise;
    logic [3:0] ev;
    e = expFlagAt(n);
    case (fdMode)
      1: fd = 1'b0;
      2: fd = 1'b1;
      3: fd = !e;
      default: fd = e;
    endcase
    hRx[n] = rx; hVf[n] = vf; hAd[n] = ad;
    pv = (n > base) ? hVf[n-1] : 1'b0;
    pa = (n > base) ? hAd[n-1] : 1'b0;
    fall = mOpen && pv && !vf;
    rise = !mOpen && (n > base) && !pv && vf;
    ev[0] = (e != fd);
    ev[1] = pa && pv && !asig;
    ev[2] = fall && !eof;
    ev[3] = (mOpen && !mReached && ovf) || (mOvfJust && !ovf);
    mOvfJust = 1'b0;
    if (mOpen) begin
      if (fall) mOpen = 1'b0;
      else if (!mReached && nb) begin
        mBytes++;
        if (mBytes == OVF) begin mReached = 1'b1; mOvfJust = 1'b1; end
      end
    end else if (rise) begin
      mOpen = 1'b1; mBytes = 0; mReached = 1'b0;
    end
    if (clr) begin
      mCnt16 = 0; mCnt4 = 0; mFrm16 = 0; mFrm4 = 0; mSticky = '0;
    end else begin
      mCnt16 = sat(mCnt16 + $countones(ev), 65535);
      mCnt4  = sat(mCnt4 + $countones(ev), 15);
      mFrm16 = sat(mFrm16 + int'(fall), 65535);
      mFrm4  = sat(mFrm4 + int'(fall), 15);
      mSticky = mSticky | ev;
    end
    @(posedge clk); #1;
    chk("ErrVec", 32'(bus16.ErrVec), 32'(ev));
    chk("ErrVec4", 32'(bus4.ErrVec), 32'(ev));
    chk("ErrSticky", 32'(bus16.ErrSticky), 32'(mSticky));
    chk("ErrCnt16", 32'(bus16.ErrCnt), 32'(mCnt16));
    chk("ErrCnt4", 32'(bus4.ErrCnt), 32'(mCnt4));
    chk("FrameCnt16", 32'(bus16.FrameCnt), 32'(mFrm16));
    chk("FrameCnt4", 32'(bus4.FrameCnt), 32'(mFrm4));
    n++;
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin rx = b[k]; cyc(); end
  endtask

  // Async reset mid-cycle: outputs must drop at once, model restarts
  task automatic doReset();
    rstN = 1'b0;
    #2;
    chk("rstVec", 32'(bus16.ErrVec), 0);
    chk("rstSticky", 32'(bus16.ErrSticky), 0);
    chk("rstErrCnt", 32'(bus16.ErrCnt), 0);
    chk("rstFrameCnt", 32'(bus16.FrameCnt), 0);
    chk("rstErrCnt4", 32'(bus4.ErrCnt), 0);
    chk("rstFrameCnt4", 32'(bus4.FrameCnt), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    base = n;
    mOpen = 1'b0; mReached = 1'b0; mOvfJust = 1'b0; mBytes = 0;
    mCnt16 = 0; mCnt4 = 0; mFrm16 = 0; mFrm4 = 0; mSticky = '0;
  endtask

  // Random cycle inside the frame soak
  task automatic rcyc();
    rx   = 1'($urandom_range(0, 1));
    nb   = 1'($urandom_range(0, 1));
    asig = lastAb ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
    ad   = ($urandom_range(0, 5) == 0);
    eof  = ($urandom_range(0, 4) != 0);
    ovf  = ($urandom_range(0, 19) == 0);
    clr  = ($urandom_range(0, 29) == 0);
    fdMode = ($urandom_range(0, 19) == 0) ? 3 : 0;
    cyc();
    lastAb = ad && vf;
  endtask

  initial begin
    rx = 1'b1; fd = 1'b0; ad = 1'b0; asig = 1'b0; vf = 1'b0;
    eof = 1'b0; nb = 1'b0; ovf = 1'b0; clr = 1'b0; lastAb = 1'b0;
    doReset();

    // Correct flag strobe, then a missing one
    rx = 1'b1; repeat (10) cyc();
    sendByte(8'h7E); rx = 1'b1; repeat (4) cyc();
    chk("flagOkCnt", 32'(bus16.ErrCnt), 0);
    fdMode = 1; sendByte(8'h7E); rx = 1'b1; repeat (3) cyc(); fdMode = 0;
    chk("flagMissCnt", 32'(bus16.ErrCnt), 1);

    // Spurious strobe
    fdMode = 2; cyc(); fdMode = 0;
    chk("spurVec", 32'(bus16.ErrVec), 32'h1);
    chk("spurSticky", 32'(bus16.ErrSticky), 32'h1);

    // Random line bytes with occasional wrong strobes
    repeat (40) begin
      fdMode = ($urandom_range(0, 15) == 0) ? 3 : 0;
      sendByte(($urandom_range(0, 1) == 1) ? 8'h7E : 8'($urandom));
    end
    fdMode = 0; rx = 1'b1; repeat (3) cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clrCnt", 32'(bus16.ErrCnt), 0);

    // Abort inside a frame, acknowledged and not
    vf = 1'b1; cyc(); cyc();
    ad = 1'b1; cyc(); ad = 1'b0; asig = 1'b0; cyc();
    chk("abortVec", 32'(bus16.ErrVec), 32'h2);
    ad = 1'b1; cyc(); ad = 1'b0; asig = 1'b1; cyc(); asig = 1'b0;
    chk("abortOkVec", 32'(bus16.ErrVec), 0);
    vf = 1'b0; eof = 1'b1; cyc(); eof = 1'b0;
    chk("frmAbort", 32'(bus16.FrameCnt), 1);
    cyc();
    ad = 1'b1; cyc(); ad = 1'b0; asig = 1'b0; cyc();
    chk("abortNoVfVec", 32'(bus16.ErrVec), 0);

    // Exactly OVF bytes with the overflow strobe on time
    vf = 1'b1; cyc();
    for (int i = 0; i < OVF; i++) begin
      nb = 1'b1; cyc();
      if ($urandom_range(0, 7) == 0) begin nb = 1'b0; cyc(); end
    end
    nb = 1'b0; ovf = 1'b1; cyc(); ovf = 1'b0;
    chk("ovfOkVec", 32'(bus16.ErrVec), 0);
    nb = 1'b1; repeat (3) cyc(); nb = 1'b0;
    vf = 1'b0; eof = 1'b1; cyc(); eof = 1'b0;
    chk("frmOvf", 32'(bus16.FrameCnt), 2);
    cyc();

    // Overflow one byte early
    vf = 1'b1; cyc();
    for (int i = 0; i < OVF-1; i++) begin nb = 1'b1; cyc(); end
    nb = 1'b0; ovf = 1'b1; cyc(); ovf = 1'b0;
    chk("ovfEarlyVec", 32'(bus16.ErrVec), 32'h8);
    vf = 1'b0; eof = 1'b1; cyc(); eof = 1'b0; cyc();

    // Abort and EoF violations in the same cycle, then again under clear
    vf = 1'b1; cyc(); cyc();
    ad = 1'b1; cyc(); ad = 1'b0; vf = 1'b0; asig = 1'b0; eof = 1'b0;
    prev = mCnt16; cyc();
    chk("comboVec", 32'(bus16.ErrVec), 32'h6);
    chk("comboCnt", 32'(bus16.ErrCnt), 32'(prev + 2));
    vf = 1'b1; cyc(); cyc();
    ad = 1'b1; cyc(); ad = 1'b0; vf = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
    chk("comboClrVec", 32'(bus16.ErrVec), 32'h6);
    chk("comboClrCnt", 32'(bus16.ErrCnt), 0);
    cyc();

    // Saturation of the 4-bit instance
    clr = 1'b1; cyc(); clr = 1'b0;
    fdMode = 2; rx = 1'b1; repeat (20) cyc(); fdMode = 0;
    chk("sat16", 32'(bus16.ErrCnt), 20);
    chk("sat4", 32'(bus4.ErrCnt), 15);
    cyc();

    // Reset in the middle of a frame; its later fall is ignored
    vf = 1'b1; cyc(); nb = 1'b1; repeat (3) cyc(); nb = 1'b0;
    doReset();
    repeat (3) cyc();
    vf = 1'b0; eof = 1'b0; cyc();
    chk("rstFallVec", 32'(bus16.ErrVec), 0);
    chk("rstFallFrm", 32'(bus16.FrameCnt), 0);
    cyc();

    // Random frames, including back-to-back ones
    repeat (10) begin
      vf = 1'b0; repeat ($urandom_range(0, 3)) rcyc();
      vf = 1'b1; repeat ($urandom_range(2, 12)) rcyc();
      vf = 1'b0; rcyc();
    end
    vf = 1'b0; ad = 1'b0; clr = 1'b0; fdMode = 0; repeat (4) rcyc();
    clr = 1'b0; fdMode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_checker.md
# hdlc_rx_checker

Synthesizable, parametrised run-time checker for the HDLC receive path. It observes the serial Rx line and the Rx status strobes, independently predicts flag, abort, end-of-frame and overflow behaviour, and reports mismatches. Errors are reported as per-class pulses, sticky flags and saturating counters. It sits beside the Rx module in both the test bench and FPGA debug builds, so the same checks run in silicon and in simulation.

## Interface
Parameters:
- FLAG_LATENCY, 2: cycles from the flag's last bit on Rx to the expected Rx_FlagDetect.
- OVF_BYTES, 130: Rx_NewByte count within one frame that must produce Rx_Overflow.
- CNT_W, 16: width of every counter output.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Rx  in  1  serial receive line.
- Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame, Rx_EoF, Rx_NewByte, Rx_Overflow  in  1 each  Rx module status.
- ErrClr  in  1  synchronous clear of counters and sticky flags.
- ErrVec  out  4  one-cycle error pulses: [0] flag, [1] abort, [2] EoF, [3] overflow.
- ErrSticky  out  4  OR-accumulated ErrVec.
- ErrCnt  out  CNT_W  total errors, saturating.
- FrameCnt  out  CNT_W  completed frames, saturating.

## Operation
- Shift register: sr <= {sr[6:0], Rx} every cycle. fill counts 0..8 and saturates at 8. No pattern matches while fill < 8.
- Flag match: sr == 8'b0111_1110. The match is delayed FLAG_LATENCY-1 cycles into exp_flag.
- Flag error: exp_flag != Rx_FlagDetect. A missing strobe and a spurious strobe are both errors.
- Abort error: (Rx_AbortDetect && Rx_ValidFrame) in cycle t, and Rx_AbortSignal is low in t+1.
- EoF error: Rx_ValidFrame falls in cycle t, and Rx_EoF is low in t+1.
- Frame FSM, S_IDLE / S_FRAME / S_OVF:
  - S_IDLE -> S_FRAME on a rising Rx_ValidFrame; bcnt is cleared.
  - S_FRAME: bcnt increments on Rx_NewByte. When bcnt reaches OVF_BYTES, go to S_OVF and expect Rx_Overflow in the next cycle; if it is missing, raise an overflow error.
  - S_FRAME: Rx_Overflow while bcnt < OVF_BYTES is an overflow error.
  - S_FRAME or S_OVF -> S_IDLE on a falling Rx_ValidFrame; FrameCnt increments.
  - S_OVF ignores Rx_NewByte.
- bcnt width: $clog2(OVF_BYTES+1).
- Counters: ErrCnt adds popcount(ErrVec), from 0 to 4 per cycle, and saturates at all-ones. FrameCnt also saturates.
- ErrClr has priority: ErrCnt, FrameCnt and ErrSticky clear in that cycle, and events in the same cycle are not counted. ErrVec still pulses.

## Timing
- Reset values: ErrVec 0, ErrSticky 0, ErrCnt 0, FrameCnt 0, FSM in S_IDLE, sr 0, fill 0, all pipelines 0.
- Reset is asynchronous. Deasserting it mid-frame restarts in S_IDLE. The frame that was open is neither counted nor checked for EoF.
- ErrVec is registered and pulses one cycle after the violated expectation cycle. ErrSticky and ErrCnt update on the same edge as ErrVec.
- Rx_ValidFrame already high at reset release is not treated as a rising edge; the FSM waits for the next rise.
- Back-to-back frames (fall then rise on consecutive cycles) are each counted and checked.
- Simultaneous abort and EoF violations in one cycle set both ErrVec bits, and ErrCnt += 2.

## Structure
- Package hdlc_chk_pkg holds:
  - the FSM state enum;
  - FLAG_PATTERN = 8'h7E and ABORT_PATTERN = 8'h7F;
  - the ErrVec index constants (ERR_FLAG, ERR_ABORT, ERR_EOF, ERR_OVF).
- Sub-module hdlc_sat_cnt: a CNT_W saturating counter with increment amount and synchronous clear, instantiated for ErrCnt and FrameCnt.

## Test plan
- Rx = 0111_1110 after reset idle; DUT model raises Rx_FlagDetect at FLAG_LATENCY=2 -> ErrVec stays 0. Remove the strobe -> ErrVec[0] pulses, ErrCnt = 1.
- Rx_FlagDetect high with no flag on Rx -> ErrVec[0] = 1, ErrSticky = 4'b0001.
- Rx_AbortDetect && Rx_ValidFrame, Rx_AbortSignal held low -> ErrVec[1] pulses. The same case with Rx_ValidFrame low -> no error.
- Frame with exactly 130 Rx_NewByte and Rx_Overflow one cycle later -> no error, FrameCnt increments on the fall. With 129 bytes and Rx_Overflow asserted -> ErrVec[3].
- Fall of Rx_ValidFrame without Rx_EoF, combined in the same cycle with an abort violation -> ErrVec = 4'b0110, ErrCnt += 2. ErrClr in that same cycle -> ErrCnt = 0.
- CNT_W = 4: drive 20 flag errors -> ErrCnt saturates at 15. Assert Rst mid-frame -> all outputs 0, no EoF error on the next fall.
